// File: rtl/amo_ctl_if.sv
// rtl/amo_ctl_if.sv - fetch/decode/bus signal bundle for the atomic micro-op sequencer
interface amo_ctl_if #(parameter int XLEN = 64);
    logic [31:0]     ir;
    logic            ir_valid;
    logic            stall;
    logic            flush;
    logic            step_ack;
    logic            lock_gnt;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] lr_addr;
    logic            lr_ret;
    logic            snoop_we;
    logic [XLEN-1:0] snoop_addr;
    logic            clr_resv;
    logic [1:0]      step;
    logic            amo_act;
    logic            fetch_hold;
    logic            lock_req;
    logic            sc_fail;
    logic            resv_valid;
    logic            amo_done;

    modport master (
        output ir, ir_valid, stall, flush, step_ack, lock_gnt, rs1_val,
               lr_addr, lr_ret, snoop_we, snoop_addr, clr_resv,
        input  step, amo_act, fetch_hold, lock_req, sc_fail, resv_valid, amo_done
    );

    modport slave (
        input  ir, ir_valid, stall, flush, step_ack, lock_gnt, rs1_val,
               lr_addr, lr_ret, snoop_we, snoop_addr, clr_resv,
        output step, amo_act, fetch_hold, lock_req, sc_fail, resv_valid, amo_done
    );
endinterface

// File: rtl/amo_ctl.sv
// rtl/amo_ctl.sv - AMO/LR/SC micro-op sequencer with bus lock and LR/SC reservation
module amo_ctl #(
    parameter int XLEN      = 64,
    parameter int RESV_GRAN = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    amo_ctl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOCK, SEQ} state_t;

    localparam logic [4:0] F5_LR = 5'b00010;
    localparam logic [4:0] F5_SC = 5'b00011;

    state_t     state, state_nx;
    logic [1:0] step, step_nx;
    logic [1:0] last_step;
    logic       op_lr, op_sc;
    logic       sc_fail_q, sc_fail_nx;
    logic       resv_valid_q;
    logic [XLEN-RESV_GRAN-1:0] resv_addr;

    logic [4:0] f5;
    logic       dec_hit;
    logic [1:0] dec_last;
    logic       detect;
    logic       last_acc;
    logic       snoop_hit;
    logic       resv_kill;
    logic       unused_bits;

    assign f5 = bus.ir[31:27];

    always_comb begin
        dec_hit  = 1'b0;
        dec_last = 2'd0;
        if (bus.ir[6:0] == 7'b0101111 && bus.ir[14:12] == 3'b010) begin
            case (f5)
                5'b00001: begin dec_hit = 1'b1; dec_last = 2'd1; end
                5'b00000, 5'b00100, 5'b01100, 5'b01000,
                5'b10000, 5'b10100, 5'b11000, 5'b11100:
                          begin dec_hit = 1'b1; dec_last = 2'd2; end
                F5_LR, F5_SC:
                          begin dec_hit = 1'b1; dec_last = 2'd0; end
                default: ;
            endcase
        end
    end

    assign detect   = rst_n && state == IDLE && bus.ir_valid && dec_hit && !bus.stall && !bus.flush;
    assign last_acc = state == SEQ && bus.step_ack && !bus.stall && !bus.flush && step == last_step;

    always_comb begin
        state_nx   = state;
        step_nx    = step;
        sc_fail_nx = sc_fail_q;
        if (bus.flush) begin
            state_nx   = IDLE;
            step_nx    = 2'd0;
            sc_fail_nx = 1'b0;
        end else if (!bus.stall) begin
            case (state)
                IDLE: if (detect) begin
                    state_nx = (f5 == F5_LR) ? SEQ : LOCK;
                    step_nx  = 2'd0;
                end
                LOCK: if (bus.lock_gnt) begin
                    state_nx = SEQ;
                    step_nx  = 2'd0;
                    if (op_sc)
                        sc_fail_nx = !(resv_valid_q &&
                                       bus.rs1_val[XLEN-1:RESV_GRAN] == resv_addr);
                end
                SEQ: if (bus.step_ack) begin
                    if (step == last_step) begin
                        state_nx   = IDLE;
                        step_nx    = 2'd0;
                        sc_fail_nx = 1'b0;
                    end else begin
                        step_nx = step + 2'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 2'd0;
            sc_fail_q <= 1'b0;
            last_step <= 2'd0;
            op_lr     <= 1'b0;
            op_sc     <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            sc_fail_q <= sc_fail_nx;
            if (detect) begin
                last_step <= dec_last;
                op_lr     <= (f5 == F5_LR);
                op_sc     <= (f5 == F5_SC);
            end
        end
    end

    // A snoop hitting the address being reserved this very cycle must also kill it.
    assign snoop_hit = bus.snoop_we &&
        ((resv_valid_q && bus.snoop_addr[XLEN-1:RESV_GRAN] == resv_addr) ||
         (bus.lr_ret && bus.snoop_addr[XLEN-1:RESV_GRAN] == bus.lr_addr[XLEN-1:RESV_GRAN]));
    assign resv_kill = bus.clr_resv || snoop_hit || (last_acc && op_sc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resv_valid_q <= 1'b0;
            resv_addr    <= '0;
        end else begin
            if (bus.lr_ret)
                resv_addr <= bus.lr_addr[XLEN-1:RESV_GRAN];
            if (resv_kill)
                resv_valid_q <= 1'b0;
            else if (bus.lr_ret)
                resv_valid_q <= 1'b1;
        end
    end

    assign bus.step       = step;
    assign bus.amo_act    = (state == SEQ);
    assign bus.fetch_hold = (state != IDLE) || detect;
    assign bus.lock_req   = (state == LOCK) || (state == SEQ && !op_lr) || detect;
    assign bus.sc_fail    = sc_fail_q;
    assign bus.resv_valid = resv_valid_q;
    assign bus.amo_done   = last_acc;

    assign unused_bits = ^{bus.ir[26:15], bus.ir[11:7], bus.rs1_val[RESV_GRAN-1:0],
                           bus.lr_addr[RESV_GRAN-1:0], bus.snoop_addr[RESV_GRAN-1:0]};
endmodule
